mux_nx1_arb: RTL and testbench

- Parametrised N:1 registered data multiplexer with a valid/ready handshake on each input channel and on the output.
- Generalises the 2:1 combinational mux to WIDTH-bit data and NUM_CH channels.
- Two modes:
  - Manual select (mode 0).
  - Round-robin arbitration across channels with pending data (mode 1).
- Sits between multiple producer blocks and a single consumer stage. Holds output stable under backpressure.

---
 rtl/mux_nx1_arb.sv | 98 +++++++++
 tb/tb_mux_nx1_arb.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/mux_nx1_arb.sv
// mux_nx1_arb: N:1 registered data mux with valid/ready on every channel.
// mode 0 forwards the channel chosen by sel; mode 1 arbitrates round-robin
// among requesting channels, starting the search just after the last winner.
// The output register holds its contents while the consumer stalls.
module mux_nx1_arb #(
  parameter int WIDTH  = 8,
  parameter int NUM_CH = 4,
  parameter int SEL_W  = $clog2(NUM_CH)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CH*WIDTH-1:0] in_data,
  input  logic [NUM_CH-1:0]       in_valid,
  output logic [NUM_CH-1:0]       in_ready,
  input  logic                    mode,
  input  logic [SEL_W-1:0]        sel,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_ch,
  output logic                    out_valid,
  input  logic                    out_ready
);

  // Every value sel can take, so an out-of-range sel reads a zero valid bit.
  localparam int                SEL_SPAN = 1 << SEL_W;
  localparam logic [SEL_W:0]    NUM_CH_L = (SEL_W + 1)'(NUM_CH);
  localparam logic [SEL_W-1:0]  LAST_RST = SEL_W'(NUM_CH - 1);

  logic [WIDTH-1:0]    ch_data [NUM_CH];
  logic [SEL_SPAN-1:0] valid_ext;
  logic                load;
  logic                grant_valid;
  logic [SEL_W-1:0]    grant_ch;
  logic [SEL_W-1:0]    last_ch;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_unpack
    assign ch_data[k] = in_data[k*WIDTH +: WIDTH];
  end

  assign valid_ext = SEL_SPAN'(in_valid);

  // The output register can take a word when empty or being drained now.
  assign load = !out_valid || out_ready;

  // Pick the channel to forward: direct select, or round-robin search.
  always_comb begin
    int idx;
    // NOTE: every combinational output gets a default before any branch so
    // no path leaves it unassigned, which would otherwise infer a latch.
    grant_valid = 1'b0;
    grant_ch    = '0;
    idx         = 0;
    if (!mode) begin
      if (({1'b0, sel} < NUM_CH_L) && valid_ext[sel]) begin
        grant_valid = 1'b1;
        grant_ch    = sel;
      end
    end else begin
      // Walk from the farthest candidate (last_ch itself) to the nearest
      // (last_ch+1) so the nearest requester is written last and wins.
      for (int i = NUM_CH; i >= 1; i--) begin
        idx = int'(last_ch) + i;
        if (idx >= NUM_CH) idx = idx - NUM_CH;
        if (valid_ext[idx[SEL_W-1:0]]) begin
          grant_valid = 1'b1;
          grant_ch    = idx[SEL_W-1:0];
        end
      end
    end
  end

  // Accept only on the granted channel, and only when the register can load.
  always_comb begin
    in_ready = '0;
    if (load && grant_valid) in_ready[grant_ch] = 1'b1;
  end

  // Output register and round-robin pointer; both move only on a transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      out_data  <= '0;
      out_ch    <= '0;
      out_valid <= 1'b0;
      last_ch   <= LAST_RST;
    end else if (load) begin
      if (grant_valid) begin
        out_data  <= ch_data[grant_ch];
        out_ch    <= grant_ch;
        out_valid <= 1'b1;
        last_ch   <= grant_ch;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mux_nx1_arb.sv
// Testbench for mux_nx1_arb: directed vectors, with expected output words
// queued by the stimulus and compared by an independent output monitor.
module tb_mux_nx1_arb;

  typedef struct packed {
    logic [1:0] ch;
    logic [7:0] data;
  } exp_t;

  logic        clk;
  logic        rst_n;
  // 4-channel instance
  logic [31:0] in_data;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic        mode;
  logic [1:0]  sel;
  logic [7:0]  out_data;
  logic [1:0]  out_ch;
  logic        out_valid;
  logic        out_ready;
  // 3-channel instance (non-power-of-two, out-of-range select)
  logic [23:0] in_data3;
  logic [2:0]  in_valid3;
  logic [2:0]  in_ready3;
  logic        mode3;
  logic [1:0]  sel3;
  logic [7:0]  out_data3;
  logic [1:0]  out_ch3;
  logic        out_valid3;
  logic        out_ready3;

  exp_t sb[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_pass   = 0;

  mux_nx1_arb #(.WIDTH(8), .NUM_CH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .mode(mode), .sel(sel),
    .out_data(out_data), .out_ch(out_ch), .out_valid(out_valid),
    .out_ready(out_ready)
  );

  mux_nx1_arb #(.WIDTH(8), .NUM_CH(3)) dut3 (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data3), .in_valid(in_valid3), .in_ready(in_ready3),
    .mode(mode3), .sel(sel3),
    .out_data(out_data3), .out_ch(out_ch3), .out_valid(out_valid3),
    .out_ready(out_ready3)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // One cycle on the 4-channel instance: check in_ready mid-cycle and, if a
  // transfer is expected, queue the word the output must later present.
  task automatic step(input string name, input logic [3:0] exp_rdy,
                      input bit push, input logic [7:0] d, input logic [1:0] c);
    exp_t e;
    @(negedge clk);
    check(name, 32'(in_ready), 32'(exp_rdy));
    if (push) begin
      e.ch   = c;
      e.data = d;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  // One cycle on the 3-channel instance with direct checks.
  task automatic step3(input string name, input logic [2:0] exp_rdy,
                       input logic exp_vld, input logic [7:0] d, input logic [1:0] c);
    @(negedge clk);
    check({name, "_rdy"}, 32'(in_ready3), 32'(exp_rdy));
    @(posedge clk);
    #1;
    check({name, "_vld"}, 32'(out_valid3), 32'(exp_vld));
    if (exp_vld) begin
      check({name, "_data"}, 32'(out_data3), 32'(d));
      check({name, "_ch"}, 32'(out_ch3), 32'(c));
    end
  endtask

  // Monitor: every word the consumer accepts must be the next one queued.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_checks++;
        $display("FAIL sb_unexpected: got word 0x%0h ch %0d, expected none", out_data, out_ch);
      end else begin
        mon_e = sb.pop_front();
        check("mon_data", 32'(out_data), 32'(mon_e.data));
        check("mon_ch", 32'(out_ch), 32'(mon_e.ch));
      end
    end
  end

  initial begin
    rst_n      = 1'b0;
    in_data    = '0;
    in_valid   = '0;
    mode       = 1'b0;
    sel        = '0;
    out_ready  = 1'b1;
    in_data3   = {8'hC2, 8'hC1, 8'hC0};
    in_valid3  = '0;
    mode3      = 1'b0;
    sel3       = '0;
    out_ready3 = 1'b1;

    // Reset state
    #2;
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_out_data", 32'(out_data), 32'h0);
    check("rst_out_ch", 32'(out_ch), 32'h0);
    check("rst_in_ready", 32'(in_ready), 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Basic manual transfer from channel 2
    mode = 1'b0; sel = 2'd2; in_valid = 4'b0100; in_data = 32'h00A5_0000;
    step("basic_rdy", 4'b0100, 1'b1, 8'hA5, 2'd2);
    check("basic_vld", 32'(out_valid), 32'h1);
    in_valid = 4'b0000;
    step("idle_rdy", 4'b0000, 1'b0, 8'h00, 2'd0);
    check("idle_vld", 32'(out_valid), 32'h0);

    // Word in flight under backpressure, then asynchronous reset discards it
    in_valid = 4'b0100; in_data = 32'h005A_0000; out_ready = 1'b0;
    step("pre_rst_rdy", 4'b0100, 1'b0, 8'h00, 2'd0);
    check("pre_rst_vld", 32'(out_valid), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_vld", 32'(out_valid), 32'h0);
    check("mid_rst_data", 32'(out_data), 32'h0);
    in_valid = 4'b0000; out_ready = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Round-robin fairness: all request, first search starts at channel 0
    mode = 1'b1; in_valid = 4'b1111; in_data = 32'h1312_1110;
    step("rr0", 4'b0001, 1'b1, 8'h10, 2'd0);
    step("rr1", 4'b0010, 1'b1, 8'h11, 2'd1);
    step("rr2", 4'b0100, 1'b1, 8'h12, 2'd2);
    step("rr3", 4'b1000, 1'b1, 8'h13, 2'd3);
    step("rr4", 4'b0001, 1'b1, 8'h10, 2'd0);
    step("rr5", 4'b0010, 1'b1, 8'h11, 2'd1);

    // Mode switch: manual grant moves the pointer, round-robin resumes after it
    mode = 1'b0; sel = 2'd3;
    step("ms_manual", 4'b1000, 1'b1, 8'h13, 2'd3);
    mode = 1'b1;
    step("ms_rr", 4'b0001, 1'b1, 8'h10, 2'd0);

    // Skip and wrap: last grant ch3, channels 0 and 2 requesting
    mode = 1'b0; sel = 2'd3;
    step("sw_setup", 4'b1000, 1'b1, 8'h13, 2'd3);
    mode = 1'b1; in_valid = 4'b0101;
    step("sw0", 4'b0001, 1'b1, 8'h10, 2'd0);
    step("sw1", 4'b0100, 1'b1, 8'h12, 2'd2);
    step("sw2", 4'b0001, 1'b1, 8'h10, 2'd0);
    step("sw3", 4'b0100, 1'b1, 8'h12, 2'd2);
    in_valid = 4'b0100;
    step("lone0", 4'b0100, 1'b1, 8'h12, 2'd2);
    step("lone1", 4'b0100, 1'b1, 8'h12, 2'd2);

    // Backpressure: 8'h33 from channel 1 held for five stalled cycles
    mode = 1'b0; sel = 2'd1; in_valid = 4'b0010; in_data = 32'h1312_3310;
    step("bp_load", 4'b0010, 1'b1, 8'h33, 2'd1);
    out_ready = 1'b0; mode = 1'b1; in_valid = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      step("bp_stall_rdy", 4'b0000, 1'b0, 8'h00, 2'd0);
      check("bp_stall_data", 32'(out_data), 32'h33);
      check("bp_stall_ch", 32'(out_ch), 32'h1);
    end
    out_ready = 1'b1;
    step("bp_release0", 4'b0100, 1'b1, 8'h12, 2'd2);
    check("bp_release0_vld", 32'(out_valid), 32'h1);
    step("bp_release1", 4'b1000, 1'b1, 8'h13, 2'd3);
    check("bp_release1_vld", 32'(out_valid), 32'h1);
    in_valid = 4'b0000;
    step("drain", 4'b0000, 1'b0, 8'h00, 2'd0);
    check("drain_vld", 32'(out_valid), 32'h0);
    check("sb_drained", 32'(sb.size()), 32'h0);

    // 3-channel instance: out-of-range and non-requesting selects never grant
    mode3 = 1'b0; sel3 = 2'd0; in_valid3 = 3'b111;
    step3("n3_sel0", 3'b001, 1'b1, 8'hC0, 2'd0);
    sel3 = 2'd3;
    step3("n3_sel3", 3'b000, 1'b0, 8'h00, 2'd0);
    sel3 = 2'd0;
    step3("n3_sel0b", 3'b001, 1'b1, 8'hC0, 2'd0);
    sel3 = 2'd1; in_valid3 = 3'b101;
    step3("n3_noreq", 3'b000, 1'b0, 8'h00, 2'd0);
    // Round-robin wrap modulo 3 after last grant ch0
    mode3 = 1'b1; in_valid3 = 3'b111;
    step3("n3_rr1", 3'b010, 1'b1, 8'hC1, 2'd1);
    step3("n3_rr2", 3'b100, 1'b1, 8'hC2, 2'd2);
    step3("n3_rr0", 3'b001, 1'b1, 8'hC0, 2'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
